// File: rtl/pspin_hostmem_dma_wr.sv
// PsPIN host-memory write adapter: buffers one AXI4 INCR write burst, then hands it to a
// Corundum DMA write engine through one descriptor plus a segmented RAM read port.
module pspin_hostmem_dma_wr #(
  parameter int DMA_ADDR_WIDTH     = 64,
  parameter int DMA_IMM_WIDTH      = 32,
  parameter int DMA_LEN_WIDTH      = 16,
  parameter int DMA_TAG_WIDTH      = 16,
  parameter int RAM_SEL_WIDTH      = 4,
  parameter int RAM_ADDR_WIDTH     = 16,
  parameter int RAM_SEG_COUNT      = 2,
  parameter int RAM_SEG_DATA_WIDTH = 256,
  parameter int RAM_SEG_ADDR_WIDTH = RAM_ADDR_WIDTH - $clog2(RAM_SEG_COUNT * (RAM_SEG_DATA_WIDTH / 8)),
  parameter int ADDR_WIDTH         = 64,
  parameter int DATA_WIDTH         = 512,
  parameter int STRB_WIDTH         = DATA_WIDTH / 8,
  parameter int ID_WIDTH           = 8,
  parameter int AWUSER_WIDTH       = 1,
  parameter int WUSER_WIDTH        = 1,
  parameter int BUSER_WIDTH        = 1,
  parameter int BUF_DEPTH          = 64
) (
  input  logic                                       clk,
  input  logic                                       rstn,
  output logic [DMA_ADDR_WIDTH-1:0]                  m_axis_write_desc_dma_addr,
  output logic [RAM_SEL_WIDTH-1:0]                   m_axis_write_desc_ram_sel,
  output logic [RAM_ADDR_WIDTH-1:0]                  m_axis_write_desc_ram_addr,
  output logic [DMA_IMM_WIDTH-1:0]                   m_axis_write_desc_imm,
  output logic                                       m_axis_write_desc_imm_en,
  output logic [DMA_LEN_WIDTH-1:0]                   m_axis_write_desc_len,
  output logic [DMA_TAG_WIDTH-1:0]                   m_axis_write_desc_tag,
  output logic                                       m_axis_write_desc_valid,
  input  logic                                       m_axis_write_desc_ready,
  input  logic [DMA_TAG_WIDTH-1:0]                   s_axis_write_desc_status_tag,
  input  logic [3:0]                                 s_axis_write_desc_status_error,
  input  logic                                       s_axis_write_desc_status_valid,
  input  logic [RAM_SEG_COUNT*RAM_SEL_WIDTH-1:0]      ram_rd_cmd_sel,
  input  logic [RAM_SEG_COUNT*RAM_SEG_ADDR_WIDTH-1:0] ram_rd_cmd_addr,
  input  logic [RAM_SEG_COUNT-1:0]                   ram_rd_cmd_valid,
  output logic [RAM_SEG_COUNT-1:0]                   ram_rd_cmd_ready,
  output logic [RAM_SEG_COUNT*RAM_SEG_DATA_WIDTH-1:0] ram_rd_resp_data,
  output logic [RAM_SEG_COUNT-1:0]                   ram_rd_resp_valid,
  input  logic [RAM_SEG_COUNT-1:0]                   ram_rd_resp_ready,
  input  logic [ID_WIDTH-1:0]                        s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]                      s_axi_awaddr,
  input  logic [7:0]                                 s_axi_awlen,
  input  logic [2:0]                                 s_axi_awsize,
  input  logic [1:0]                                 s_axi_awburst,
  input  logic                                       s_axi_awlock,
  input  logic [3:0]                                 s_axi_awcache,
  input  logic [2:0]                                 s_axi_awprot,
  input  logic [3:0]                                 s_axi_awqos,
  input  logic [3:0]                                 s_axi_awregion,
  input  logic [AWUSER_WIDTH-1:0]                    s_axi_awuser,
  input  logic                                       s_axi_awvalid,
  output logic                                       s_axi_awready,
  input  logic [DATA_WIDTH-1:0]                      s_axi_wdata,
  input  logic [STRB_WIDTH-1:0]                      s_axi_wstrb,
  input  logic                                       s_axi_wlast,
  input  logic [WUSER_WIDTH-1:0]                     s_axi_wuser,
  input  logic                                       s_axi_wvalid,
  output logic                                       s_axi_wready,
  output logic [ID_WIDTH-1:0]                        s_axi_bid,
  output logic [1:0]                                 s_axi_bresp,
  output logic [BUSER_WIDTH-1:0]                     s_axi_buser,
  output logic                                       s_axi_bvalid,
  input  logic                                       s_axi_bready
);

  localparam int OFF_W  = $clog2(STRB_WIDTH);
  localparam int BUF_AW = $clog2(BUF_DEPTH);
  localparam int SEG_AW = RAM_SEG_ADDR_WIDTH;
  localparam int SEG_DW = RAM_SEG_DATA_WIDTH;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DATA  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DESC  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic                      awready_q, wready_q, desc_valid_q, bvalid_q, en_q, err_q;
  logic [ID_WIDTH-1:0]       id_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [7:0]                len_q, cnt_q;
  logic [DMA_LEN_WIDTH-1:0]  desc_len_q;
  logic [DMA_TAG_WIDTH-1:0]  desc_tag_q, tag_cnt_q;
  logic [1:0]                bresp_q;
  logic [RAM_SEG_COUNT-1:0]  rvalid_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic [DATA_WIDTH-1:0]     buf_mem [BUF_DEPTH];

  logic aw_hs_s, w_hs_s, desc_hs_s, b_hs_s, aw_bad_s, beat_last_s, wlast_bad_s, status_hit_s;

  function automatic logic [OFF_W:0] lead_zeros(input logic [STRB_WIDTH-1:0] strb);
    logic [OFF_W:0] n;
    logic           found;
    n     = '0;
    found = 1'b0;
    for (int i = STRB_WIDTH - 1; i >= 0; i--) begin
      if (strb[i]) found = 1'b1;
      else if (!found) n = n + 1'b1;
    end
    return n;
  endfunction

  assign aw_hs_s      = s_axi_awvalid & awready_q;
  assign w_hs_s       = s_axi_wvalid & wready_q;
  assign desc_hs_s    = desc_valid_q & m_axis_write_desc_ready;
  assign b_hs_s       = bvalid_q & s_axi_bready;
  assign aw_bad_s     = (s_axi_awburst != 2'b01) || (s_axi_awsize != 3'(OFF_W)) ||
                        ({1'b0, s_axi_awlen} >= 9'(BUF_DEPTH));
  assign beat_last_s  = (cnt_q == len_q);
  assign wlast_bad_s  = (s_axi_wlast != beat_last_s);
  assign status_hit_s = s_axis_write_desc_status_valid && (s_axis_write_desc_status_tag == desc_tag_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (aw_hs_s) state_d = aw_bad_s ? ST_DRAIN : ST_DATA; else state_d = state_q;
      ST_DATA:  if (w_hs_s && beat_last_s) state_d = (err_q || wlast_bad_s) ? ST_RESP : ST_DESC;
                else state_d = state_q;
      ST_DRAIN: if (w_hs_s && beat_last_s) state_d = ST_RESP; else state_d = state_q;
      ST_DESC:  if (desc_hs_s) state_d = ST_WAIT; else state_d = state_q;
      ST_WAIT:  if (status_hit_s) state_d = ST_RESP; else state_d = state_q;
      ST_RESP:  if (b_hs_s) state_d = ST_IDLE; else state_d = state_q;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they toggle with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      desc_valid_q <= 1'b0;
      bvalid_q     <= 1'b0;
      en_q         <= 1'b0;
      err_q        <= 1'b0;
      id_q         <= '0;
      addr_q       <= '0;
      len_q        <= 8'd0;
      cnt_q        <= 8'd0;
      desc_len_q   <= '0;
      desc_tag_q   <= '0;
      tag_cnt_q    <= '0;
      bresp_q      <= RESP_OKAY;
    end else begin
      awready_q    <= (state_d == ST_IDLE);
      wready_q     <= (state_d == ST_DATA) || (state_d == ST_DRAIN);
      desc_valid_q <= (state_d == ST_DESC);
      bvalid_q     <= (state_d == ST_RESP);
      en_q         <= 1'b1;
      if (aw_hs_s) begin
        id_q   <= s_axi_awid;
        addr_q <= s_axi_awaddr;
        len_q  <= s_axi_awlen;
        cnt_q  <= 8'd0;
        err_q  <= 1'b0;
      end else if (w_hs_s) begin
        cnt_q <= cnt_q + 8'd1;
        if ((state_q == ST_DATA) && wlast_bad_s) err_q <= 1'b1;
      end
      if ((state_q == ST_DATA) && w_hs_s && beat_last_s) begin
        desc_len_q <= (DMA_LEN_WIDTH'(len_q) + DMA_LEN_WIDTH'(1)) * DMA_LEN_WIDTH'(STRB_WIDTH)
                      - DMA_LEN_WIDTH'(addr_q[OFF_W-1:0]) - DMA_LEN_WIDTH'(lead_zeros(s_axi_wstrb));
        desc_tag_q <= tag_cnt_q;
      end
      if (desc_hs_s) tag_cnt_q <= tag_cnt_q + DMA_TAG_WIDTH'(1);
      if ((state_q != ST_RESP) && (state_d == ST_RESP)) begin
        bresp_q <= ((state_q == ST_WAIT) && (s_axis_write_desc_status_error == 4'd0)) ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Burst buffer: beat k lands in row k; only written while collecting good data.
  always_ff @(posedge clk) begin
    if ((state_q == ST_DATA) && w_hs_s) buf_mem[cnt_q[BUF_AW-1:0]] <= s_axi_wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      for (int s = 0; s < RAM_SEG_COUNT; s++) begin
        if (ram_rd_cmd_valid[s] && ram_rd_cmd_ready[s]) begin
          rvalid_q[s]                 <= 1'b1;
          rdata_q[s*SEG_DW +: SEG_DW] <= buf_mem[ram_rd_cmd_addr[s*SEG_AW +: BUF_AW]][s*SEG_DW +: SEG_DW];
        end else if (ram_rd_resp_ready[s]) begin
          rvalid_q[s] <= 1'b0;
        end
      end
    end
  end

  // en_q keeps cmd_ready low while reset is asserted.
  assign ram_rd_cmd_ready  = {RAM_SEG_COUNT{en_q}} & (~rvalid_q | ram_rd_resp_ready);
  assign ram_rd_resp_valid = rvalid_q;
  assign ram_rd_resp_data  = rdata_q;

  assign m_axis_write_desc_dma_addr = DMA_ADDR_WIDTH'(addr_q);
  assign m_axis_write_desc_ram_sel  = '0;
  assign m_axis_write_desc_ram_addr = RAM_ADDR_WIDTH'(addr_q[OFF_W-1:0]);
  assign m_axis_write_desc_imm      = '0;
  assign m_axis_write_desc_imm_en   = 1'b0;
  assign m_axis_write_desc_len      = desc_len_q;
  assign m_axis_write_desc_tag      = desc_tag_q;
  assign m_axis_write_desc_valid    = desc_valid_q;

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bid     = id_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_buser   = '0;
  assign s_axi_bvalid  = bvalid_q;

  logic unused_s;
  assign unused_s = ^{ram_rd_cmd_sel, ram_rd_cmd_addr, s_axi_awlock, s_axi_awcache, s_axi_awprot,
                      s_axi_awqos, s_axi_awregion, s_axi_awuser, s_axi_wuser};

endmodule

// File: tb/tb_pspin_hostmem_dma_wr.sv
// Directed bench for pspin_hostmem_dma_wr: burst buffering, descriptor fields, RAM reads,
// error drains, status matching and asynchronous reset.
module tb_pspin_hostmem_dma_wr;
  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [63:0]  desc_dma_addr;
  logic [3:0]   desc_ram_sel;
  logic [15:0]  desc_ram_addr;
  logic [31:0]  desc_imm;
  logic         desc_imm_en;
  logic [15:0]  desc_len;
  logic [15:0]  desc_tag;
  logic         desc_valid;
  logic         desc_ready = 1'b0;
  logic [15:0]  st_tag = 16'd0;
  logic [3:0]   st_err = 4'd0;
  logic         st_valid = 1'b0;
  logic [7:0]   cmd_sel = 8'd0;
  logic [19:0]  cmd_addr = 20'd0;
  logic [1:0]   cmd_valid = 2'b00;
  logic [1:0]   cmd_ready;
  logic [511:0] resp_data;
  logic [1:0]   resp_valid;
  logic [1:0]   resp_ready = 2'b00;
  logic [7:0]   awid = 8'd0;
  logic [63:0]  awaddr = 64'd0;
  logic [7:0]   awlen = 8'd0;
  logic [2:0]   awsize = 3'd6;
  logic [1:0]   awburst = 2'b01;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [511:0] wdata = 512'd0;
  logic [63:0]  wstrb = 64'd0;
  logic         wlast = 1'b0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [7:0]   bid;
  logic [1:0]   bresp;
  logic [0:0]   buser;
  logic         bvalid;
  logic         bready = 1'b0;

  int total = 0;
  int bad = 0;
  int desc_cycles = 0;
  int snap;
  localparam logic [63:0] FULL = 64'hFFFF_FFFF_FFFF_FFFF;

  pspin_hostmem_dma_wr dut (
    .clk(clk), .rstn(rstn),
    .m_axis_write_desc_dma_addr(desc_dma_addr), .m_axis_write_desc_ram_sel(desc_ram_sel),
    .m_axis_write_desc_ram_addr(desc_ram_addr), .m_axis_write_desc_imm(desc_imm),
    .m_axis_write_desc_imm_en(desc_imm_en), .m_axis_write_desc_len(desc_len),
    .m_axis_write_desc_tag(desc_tag), .m_axis_write_desc_valid(desc_valid),
    .m_axis_write_desc_ready(desc_ready),
    .s_axis_write_desc_status_tag(st_tag), .s_axis_write_desc_status_error(st_err),
    .s_axis_write_desc_status_valid(st_valid),
    .ram_rd_cmd_sel(cmd_sel), .ram_rd_cmd_addr(cmd_addr), .ram_rd_cmd_valid(cmd_valid),
    .ram_rd_cmd_ready(cmd_ready), .ram_rd_resp_data(resp_data), .ram_rd_resp_valid(resp_valid),
    .ram_rd_resp_ready(resp_ready),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'd0), .s_axi_awprot(3'd0),
    .s_axi_awqos(4'd0), .s_axi_awregion(4'd0), .s_axi_awuser(1'b0), .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wuser(1'b0),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_buser(buser), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (desc_valid) desc_cycles <= desc_cycles + 1;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] beat(input int t, input int k);
    logic [31:0] lo, hi;
    lo = 32'hA000_0000 + 32'(t * 256 + k);
    hi = 32'hD100_0000 + 32'(t * 256 + k);
    return {{8{hi}}, {8{lo}}};
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic aw_send(input logic [7:0] id, input logic [63:0] a, input logic [7:0] l,
                         input logic [2:0] sz, input logic [1:0] bu);
    int n = 0;
    awid = id; awaddr = a; awlen = l; awsize = sz; awburst = bu; awvalid = 1'b1;
    while (!awready && n < 50) begin @(posedge clk); #1; n++; end
    check("awready", awready, 1'b1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [511:0] d, input logic [63:0] s, input logic l);
    int n = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    while (!wready && n < 50) begin @(posedge clk); #1; n++; end
    check("wready", wready, 1'b1);
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic wait_desc(input logic [63:0] a, input logic [15:0] ra, input logic [15:0] l,
                           input logic [15:0] t);
    int n = 0;
    while (!desc_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("desc_valid", desc_valid, 1'b1);
    check("desc_addr", desc_dma_addr, a);
    check("desc_ram_addr", desc_ram_addr, ra);
    check("desc_len", desc_len, l);
    check("desc_tag", desc_tag, t);
    check("desc_const", {desc_ram_sel, desc_imm, desc_imm_en}, 37'd0);
  endtask

  task automatic desc_accept();
    desc_ready = 1'b1;
    @(posedge clk); #1;
    desc_ready = 1'b0;
    check("desc_drop", desc_valid, 1'b0);
  endtask

  task automatic status(input logic [15:0] t, input logic [3:0] e);
    st_tag = t; st_err = e; st_valid = 1'b1;
    @(posedge clk); #1;
    st_valid = 1'b0;
  endtask

  task automatic wait_b(input logic [7:0] id, input logic [1:0] r);
    int n = 0;
    while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
    check("bvalid", bvalid, 1'b1);
    check("bid", bid, id);
    check("bresp", bresp, r);
    check("buser", buser, 1'b0);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("bvalid_drop", bvalid, 1'b0);
  endtask

  task automatic ram_read(input logic [9:0] a0, input logic [9:0] a1, input logic [511:0] exp);
    cmd_addr = {a1, a0}; cmd_valid = 2'b11; resp_ready = 2'b00;
    check("cmd_ready", cmd_ready, 2'b11);
    @(posedge clk); #1;
    cmd_valid = 2'b00;
    check("resp_valid", resp_valid, 2'b11);
    check("resp_data", resp_data, exp);
    @(posedge clk); #1;
    check("resp_hold", {resp_valid, resp_data}, {2'b11, exp});
    check("cmd_ready_busy", cmd_ready, 2'b00);
    resp_ready = 2'b11;
    @(posedge clk); #1;
    resp_ready = 2'b00;
    check("resp_release", resp_valid, 2'b00);
  endtask

  initial begin
    #2;
    check("reset_outs", {awready, wready, desc_valid, bvalid, bresp, bid, cmd_ready, resp_valid}, 22'd0);
    check("reset_desc", {desc_dma_addr, desc_len, desc_tag}, 96'd0);
    #20 rstn = 1'b1;
    @(posedge clk); #1;

    // Four full beats: 256-byte descriptor, tag 0, OKAY completion.
    aw_send(8'h11, 64'h1000, 8'd3, 3'd6, 2'b01);
    for (int k = 0; k < 4; k++) w_send(beat(1, k), FULL, k == 3);
    wait_desc(64'h1000, 16'd0, 16'd256, 16'd0);
    desc_accept();
    ram_read(10'd2, 10'd3, {beat(1, 3)[511:256], beat(1, 2)[255:0]});
    status(16'd0, 4'd0);
    wait_b(8'h11, 2'b00);

    // Unaligned single beat with partial last strobe: 64-16-16 = 32.
    aw_send(8'h22, 64'h2010, 8'd0, 3'd6, 2'b01);
    w_send(beat(2, 0), 64'h0000_FFFF_FFFF_FFFF, 1'b1);
    wait_desc(64'h2010, 16'h0010, 16'd32, 16'd1);
    desc_accept();
    ram_read(10'd0, 10'h040, beat(2, 0));
    status(16'd1, 4'd0);
    wait_b(8'h22, 2'b00);

    // FIXED burst, 64 beats drained.
    snap = desc_cycles;
    aw_send(8'h33, 64'h3000, 8'd63, 3'd6, 2'b00);
    for (int k = 0; k < 64; k++) w_send(beat(3, k), FULL, k == 63);
    wait_b(8'h33, 2'b10);
    check("no_desc_fixed", desc_cycles - snap, 0);

    // awlen=64 exceeds the buffer: 65 beats drained.
    snap = desc_cycles;
    aw_send(8'h34, 64'h3000, 8'd64, 3'd6, 2'b01);
    for (int k = 0; k < 65; k++) w_send(beat(3, k), FULL, k == 64);
    wait_b(8'h34, 2'b10);
    check("no_desc_long", desc_cycles - snap, 0);

    // Early wlast on beat 1 of 4.
    snap = desc_cycles;
    aw_send(8'h44, 64'h4000, 8'd3, 3'd6, 2'b01);
    for (int k = 0; k < 4; k++) w_send(beat(4, k), FULL, k == 1);
    wait_b(8'h44, 2'b10);
    check("no_desc_wlast", desc_cycles - snap, 0);

    // Stalled descriptor, mismatched status tag, then error status.
    aw_send(8'h55, 64'h5000, 8'd0, 3'd6, 2'b01);
    w_send(beat(5, 0), FULL, 1'b1);
    wait_desc(64'h5000, 16'd0, 16'd64, 16'd2);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("desc_stall", {desc_valid, desc_dma_addr, desc_len, desc_tag}, {1'b1, 64'h5000, 16'd64, 16'd2});
    end
    desc_accept();
    status(16'd7, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    check("tag_mismatch", bvalid, 1'b0);
    status(16'd2, 4'h1);
    wait_b(8'h55, 2'b10);

    // Reset while waiting for status.
    aw_send(8'h66, 64'h6008, 8'd1, 3'd6, 2'b01);
    w_send(beat(6, 0), FULL, 1'b0);
    w_send(beat(6, 1), FULL, 1'b1);
    wait_desc(64'h6008, 16'h0008, 16'd120, 16'd3);
    desc_accept();
    rstn = 1'b0;
    #1;
    check("async_reset", {awready, wready, desc_valid, bvalid, bresp, bid, cmd_ready, desc_tag}, 38'd0);
    #12 rstn = 1'b1;
    @(posedge clk); #1;
    status(16'd3, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    check("stale_status", {bvalid, desc_valid, awready}, 3'b001);
    aw_send(8'h77, 64'h7000, 8'd0, 3'd6, 2'b01);
    w_send(beat(7, 0), FULL, 1'b1);
    wait_desc(64'h7000, 16'd0, 16'd64, 16'd0);
    desc_accept();
    status(16'd0, 4'd0);
    wait_b(8'h77, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
